// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and reset constants for the dual-clock FIFO pointers.
// Functions work on up to 32-bit values; bits at or above 'width' are ignored.
package gray_pkg;

    localparam logic [31:0] GRAY_RESET = '0;
    localparam logic [31:0] BIN_RESET  = 32'd1;

    function automatic logic [31:0] width_mask(input int width);
        return (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] value, input int width);
        logic [31:0] v;
        v = value & width_mask(width);
        return v ^ (v >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
        logic [31:0] g;
        logic [31:0] b;
        g = gray & width_mask(width);
        b = g;
        for (int s = 1; s < 32; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// Enable-gated Gray-code pointer for one FIFO clock domain. The binary register runs
// one count ahead so the output is a registered bin2gray of it, with no input-to-output path.
module gray_counter
    import gray_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Clear_in,
    input  logic                     Enable_in,
    output logic [COUNTER_WIDTH-1:0] GrayCount_out
);

    logic [COUNTER_WIDTH-1:0] r_bin;
    logic [COUNTER_WIDTH-1:0] w_bin_inc;
    logic [COUNTER_WIDTH-1:0] w_gray;

    assign w_bin_inc = r_bin + COUNTER_WIDTH'(1);
    assign w_gray    = COUNTER_WIDTH'(bin2gray(32'(r_bin), COUNTER_WIDTH));

    // NOTE: non-blocking assignments keep both registers sampling pre-edge values,
    // so the output really is the Gray code of the old bin, not the incremented one.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_bin         <= COUNTER_WIDTH'(BIN_RESET);
            GrayCount_out <= COUNTER_WIDTH'(GRAY_RESET);
        end else if (Clear_in) begin
            r_bin         <= COUNTER_WIDTH'(BIN_RESET);
            GrayCount_out <= COUNTER_WIDTH'(GRAY_RESET);
        end else if (Enable_in) begin
            r_bin         <= w_bin_inc;
            GrayCount_out <= w_gray;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at N=4 and N=6, driven from shared inputs and
// compared each cycle against an enable-count model: output = k ^ (k >> 1), k mod 2^N.
module tb_gray_counter;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Clear_in = 1'b0;
    logic       Enable_in = 1'b0;
    logic [3:0] out4;
    logic [5:0] out6;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    gray_counter #(.COUNTER_WIDTH(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Clear_in(Clear_in),
        .Enable_in(Enable_in), .GrayCount_out(out4)
    );

    gray_counter #(.COUNTER_WIDTH(6)) dut6 (
        .Clk(Clk), .Rst_n(Rst_n), .Clear_in(Clear_in),
        .Enable_in(Enable_in), .GrayCount_out(out6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned gray_of(input int unsigned k);
        return k ^ (k >> 1);
    endfunction

    // Reference: number of enabled edges since the last reset or clear.
    int unsigned k4 = 0;
    int unsigned k6 = 0;
    bit          stepped = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            k4 <= 0; k6 <= 0; stepped <= 1'b0;
        end else if (Clear_in) begin
            k4 <= 0; k6 <= 0; stepped <= 1'b0;
        end else if (Enable_in) begin
            k4 <= (k4 + 1) % 16; k6 <= (k6 + 1) % 64; stepped <= 1'b1;
        end else begin
            stepped <= 1'b0;
        end
    end

    logic [3:0] prev4;
    logic [5:0] prev6;

    always @(negedge Clk) begin
        check("model4", 32'(out4), gray_of(k4));
        check("model6", 32'(out6), gray_of(k6));
        if (stepped) begin
            check("onebit4", $countones(out4 ^ prev4), 1);
            check("onebit6", $countones(out6 ^ prev6), 1);
        end
        prev4 <= out4;
        prev6 <= out6;
    end

    task automatic tick(input logic en, input logic clr);
        Enable_in = en;
        Clear_in  = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        #3 Rst_n = 1'b0;
        #1 Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    logic [3:0] seq17 [17] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};
    logic [2:0] restart [3] = '{3'h1, 3'h3, 3'h2};
    bit         seen [64];
    int         distinct;

    initial begin
        // Reset held for 3 clocks with enable asserted.
        Enable_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1 check("reset_hold", 32'(out4), 0);
        end
        Rst_n = 1'b1;
        tick(1'b1, 1'b0);
        check("first_after_reset", 32'(out4), 1);

        // Full 17-step sequence from reset, including the wrap to 0.
        Enable_in = 1'b0;
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            tick(1'b1, 1'b0);
            check($sformatf("seq[%0d]", i), 32'(out4), 32'(seq17[i]));
        end

        // Hold at 6.
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        check("reach6", 32'(out4), 32'h6);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            check("hold6", 32'(out4), 32'h6);
        end
        tick(1'b1, 1'b0);
        check("reenable7", 32'(out4), 32'h7);

        // Clear beats enable at D.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        check("reachD", 32'(out4), 32'hD);
        tick(1'b1, 1'b1);
        check("clear_wins", 32'(out4), 0);
        tick(1'b1, 1'b0);
        check("after_clear", 32'(out4), 1);

        // Asynchronous reset between edges at 5.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        check("reach5", 32'(out4), 32'h5);
        Enable_in = 1'b1;
        #3 Rst_n = 1'b0;
        #1 check("async_reset4", 32'(out4), 0);
        check("async_reset6", 32'(out6), 0);
        #2 Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("restart[%0d]", i), 32'(out4), 32'(restart[i]));
            tick(1'b1, 1'b0);
        end

        // N=6: 64 enables from reset give 64 distinct codes, ending at 0.
        Enable_in = 1'b0;
        pulse_reset();
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, 1'b0);
            seen[out6] = 1'b1;
        end
        distinct = 0;
        for (int i = 0; i < 64; i++) distinct += int'(seen[i]);
        check("n6_distinct", distinct, 64);
        check("n6_wrap", 32'(out6), 0);

        // Random enable/clear traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end
        tick(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
